// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game-flow controller: state codes, widths,
// default match parameters and a saturating score increment.
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int TIMER_W = 8;

  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_SERVE_FRAMES = 120;
  localparam int DEF_POINT_FRAMES = 60;

  localparam logic [2:0] ST_IDLE_C  = 3'd0;
  localparam logic [2:0] ST_SERVE_C = 3'd1;
  localparam logic [2:0] ST_PLAY_C  = 3'd2;
  localparam logic [2:0] ST_PAUSE_C = 3'd3;
  localparam logic [2:0] ST_POINT_C = 3'd4;
  localparam logic [2:0] ST_OVER_C  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_C,
    ST_SERVE = ST_SERVE_C,
    ST_PLAY  = ST_PLAY_C,
    ST_PAUSE = ST_PAUSE_C,
    ST_POINT = ST_POINT_C,
    ST_OVER  = ST_OVER_C
  } state_e;

  // Scores stop at the winning value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                 input logic [SCORE_W-1:0] limit);
    return (score >= limit) ? score : score + 1'b1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the game-flow controller (slave) and the
// motion/pixel datapath plus buttons (master).
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic               frame_tick;
  logic               start_btn;
  logic               pause_btn;
  logic               miss_left;
  logic               miss_right;
  logic               ball_en;
  logic               paddle_en;
  logic               ball_center;
  logic               serve_dir;
  logic [SCORE_W-1:0] left_score;
  logic [SCORE_W-1:0] right_score;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output frame_tick, start_btn, pause_btn, miss_left, miss_right,
    input  ball_en, paddle_en, ball_center, serve_dir,
    input  left_score, right_score, game_over, winner, state
  );

  modport slave (
    input  frame_tick, start_btn, pause_btn, miss_left, miss_right,
    output ball_en, paddle_en, ball_center, serve_dir,
    output left_score, right_score, game_over, winner, state
  );

endinterface

// File: rtl/pong_btn_edge.sv
// Rising-edge detector for an already-synchronised button level; a held
// button yields a single one-cycle event.
module pong_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: attract, serve countdown, play, pause, point freeze
// and game over, with score keeping and registered datapath controls.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
  input logic              clk,
  input logic              rst,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_T  = TIMER_W'(SERVE_FRAMES);
  localparam logic [TIMER_W-1:0] POINT_T  = TIMER_W'(POINT_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [SCORE_W-1:0] left_q, right_q;
  logic               dir_q, center_q, ball_en_q, paddle_en_q, over_q, winner_q;

  logic               start_rise, pause_rise;
  logic [SCORE_W-1:0] left_inc, right_inc;

  pong_btn_edge u_start_edge (.clk(clk), .rst(rst), .btn_i(bus.start_btn), .rise_o(start_rise));
  pong_btn_edge u_pause_edge (.clk(clk), .rst(rst), .btn_i(bus.pause_btn), .rise_o(pause_rise));

  assign left_inc  = sat_inc(left_q, WIN_S);
  assign right_inc = sat_inc(right_q, WIN_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      dir_q       <= 1'b1;
      center_q    <= 1'b0;
      ball_en_q   <= 1'b0;
      paddle_en_q <= 1'b0;
      over_q      <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      center_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state_q     <= ST_SERVE;
            timer_q     <= SERVE_T;
            left_q      <= '0;
            right_q     <= '0;
            dir_q       <= 1'b1;
            center_q    <= 1'b1;
            ball_en_q   <= 1'b0;
            paddle_en_q <= 1'b1;
            over_q      <= 1'b0;
            winner_q    <= 1'b0;
          end
        end

        ST_SERVE: begin
          if (bus.frame_tick) begin
            if (timer_q == TIMER_ONE) begin
              state_q   <= ST_PLAY;
              ball_en_q <= 1'b1;
            end
            if (timer_q != '0) timer_q <= timer_q - 1'b1;
          end
        end

        // A miss outranks the other miss and any pause edge in the same cycle.
        ST_PLAY: begin
          if (bus.miss_left) begin
            right_q     <= right_inc;
            dir_q       <= 1'b0;
            ball_en_q   <= 1'b0;
            paddle_en_q <= 1'b0;
            if (right_inc == WIN_S) begin
              state_q  <= ST_OVER;
              over_q   <= 1'b1;
              winner_q <= 1'b1;
            end else begin
              state_q  <= ST_POINT;
              timer_q  <= POINT_T;
              center_q <= 1'b1;
            end
          end else if (bus.miss_right) begin
            left_q      <= left_inc;
            dir_q       <= 1'b1;
            ball_en_q   <= 1'b0;
            paddle_en_q <= 1'b0;
            if (left_inc == WIN_S) begin
              state_q  <= ST_OVER;
              over_q   <= 1'b1;
              winner_q <= 1'b0;
            end else begin
              state_q  <= ST_POINT;
              timer_q  <= POINT_T;
              center_q <= 1'b1;
            end
          end else if (pause_rise) begin
            state_q     <= ST_PAUSE;
            ball_en_q   <= 1'b0;
            paddle_en_q <= 1'b0;
          end
        end

        ST_PAUSE: begin
          if (pause_rise) begin
            state_q     <= ST_PLAY;
            ball_en_q   <= 1'b1;
            paddle_en_q <= 1'b1;
          end
        end

        ST_POINT: begin
          if (bus.frame_tick) begin
            if (timer_q == TIMER_ONE) begin
              state_q     <= ST_SERVE;
              timer_q     <= SERVE_T;
              paddle_en_q <= 1'b1;
            end else if (timer_q != '0) begin
              timer_q <= timer_q - 1'b1;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          ball_en_q   <= 1'b0;
          paddle_en_q <= 1'b0;
          over_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.ball_en     = ball_en_q;
  assign bus.paddle_en   = paddle_en_q;
  assign bus.ball_center = center_q;
  assign bus.serve_dir   = dir_q;
  assign bus.left_score  = left_q;
  assign bus.right_score = right_q;
  assign bus.game_over   = over_q;
  assign bus.winner      = winner_q;

endmodule
